// File: rtl/simframe_pkg.sv
// Shared types and widths for the simulated-frame generator and its sequencer.
// Exports the sequencer state enum and the default pattern/count widths.
package simframe_pkg;

    localparam int PATTERN_WIDTH_DEF = 32;
    localparam int COUNT_WIDTH_DEF   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/simframe_sequencer.sv
// Pattern scheduler feeding the frame generator's input stream.
// Ports: clk/resetn; start/stop pulses; cfg_* run setup; busy/done/
// frames_issued status; AXIS_OUT_* pattern stream (TREADY paces issues).
module simframe_sequencer
    import simframe_pkg::*;
#(
    parameter int PATTERN_WIDTH = PATTERN_WIDTH_DEF,
    parameter int COUNT_WIDTH   = COUNT_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic                     stop,
    input  logic [PATTERN_WIDTH-1:0] cfg_first_pattern,
    input  logic [PATTERN_WIDTH-1:0] cfg_increment,
    input  logic [COUNT_WIDTH-1:0]   cfg_frame_count,
    input  logic [COUNT_WIDTH-1:0]   cfg_gap_cycles,
    output logic                     busy,
    output logic                     done,
    output logic [COUNT_WIDTH-1:0]   frames_issued,
    output logic [PATTERN_WIDTH-1:0] AXIS_OUT_TDATA,
    output logic                     AXIS_OUT_TVALID,
    input  logic                     AXIS_OUT_TREADY
);

    state_t                   state;
    logic [PATTERN_WIDTH-1:0] inc_q;
    logic [COUNT_WIDTH-1:0]   count_q;
    logic [COUNT_WIDTH-1:0]   gap_q;
    logic [COUNT_WIDTH-1:0]   remaining;
    logic [COUNT_WIDTH-1:0]   gap_cnt;
    logic                     stop_pending;

    logic handshake;
    logic finite;
    logic last_issue;

    assign handshake  = AXIS_OUT_TVALID && AXIS_OUT_TREADY;
    // count of zero selects continuous mode: remaining is never consulted
    assign finite     = (count_q != '0);
    assign last_issue = finite && (remaining == COUNT_WIDTH'(1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            inc_q           <= '0;
            count_q         <= '0;
            gap_q           <= '0;
            remaining       <= '0;
            gap_cnt         <= '0;
            stop_pending    <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            frames_issued   <= '0;
            AXIS_OUT_TDATA  <= '0;
            AXIS_OUT_TVALID <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // a stop arriving with start is simply dropped
                    if (start) begin
                        inc_q           <= cfg_increment;
                        count_q         <= cfg_frame_count;
                        gap_q           <= cfg_gap_cycles;
                        remaining       <= cfg_frame_count;
                        frames_issued   <= '0;
                        AXIS_OUT_TDATA  <= cfg_first_pattern;
                        AXIS_OUT_TVALID <= 1'b1;
                        busy            <= 1'b1;
                        stop_pending    <= 1'b0;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (handshake) begin
                        frames_issued  <= frames_issued + COUNT_WIDTH'(1);
                        AXIS_OUT_TDATA <= AXIS_OUT_TDATA + inc_q;
                        if (finite) begin
                            remaining <= remaining - COUNT_WIDTH'(1);
                        end
                        if (last_issue || stop_pending || stop) begin
                            state           <= IDLE;
                            done            <= 1'b1;
                            busy            <= 1'b0;
                            AXIS_OUT_TVALID <= 1'b0;
                            stop_pending    <= 1'b0;
                        end else if (gap_q != '0) begin
                            state           <= GAP;
                            gap_cnt         <= gap_q - COUNT_WIDTH'(1);
                            AXIS_OUT_TVALID <= 1'b0;
                        end
                    end else if (stop) begin
                        // the offered pattern must still complete
                        stop_pending <= 1'b1;
                    end
                end
                GAP: begin
                    if (stop) begin
                        state        <= IDLE;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        stop_pending <= 1'b0;
                    end else if (gap_cnt == '0) begin
                        state           <= ISSUE;
                        AXIS_OUT_TVALID <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - COUNT_WIDTH'(1);
                    end
                end
                default: begin
                    state           <= IDLE;
                    busy            <= 1'b0;
                    AXIS_OUT_TVALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/simframe_sequencer.md
# simframe_sequencer

Pattern scheduler that drives the pattern input stream of the simulated-frame generator. On a start pulse it issues a configurable number of patterns (or runs until stopped), beginning at a programmed first value, stepping by a programmed increment, and spacing issues by a programmed idle gap. It sits between the control-register block and the frame generator's input stream. The generator's backpressure paces it to one pattern per frame.

## Interface
- PATTERN_WIDTH, 32: width of a pattern word and of the output stream data.
- COUNT_WIDTH, 32: width of the frame-count, gap and issued-count fields.

- clk  in  1  single clock; all logic is rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- stop  in  1  one-cycle pulse; ends a run early.
- cfg_first_pattern  in  PATTERN_WIDTH  first pattern of a run.
- cfg_increment  in  PATTERN_WIDTH  added to the pattern after each issue.
- cfg_frame_count  in  COUNT_WIDTH  patterns per run; 0 means continuous.
- cfg_gap_cycles  in  COUNT_WIDTH  idle cycles inserted between issues.
- busy  out  1  high from the cycle after an accepted start until the run ends.
- done  out  1  one-cycle pulse when a run ends.
- frames_issued  out  COUNT_WIDTH  patterns accepted in the current or last run.
- AXIS_OUT_TDATA  out  PATTERN_WIDTH  pattern to the frame generator.
- AXIS_OUT_TVALID  out  1  pattern valid.
- AXIS_OUT_TREADY  in  1  generator accepts the pattern.

## Operation
- States:
  - IDLE: busy=0, TVALID=0.
  - ISSUE: TVALID=1.
  - GAP: TVALID=0, gap counter running.
- IDLE + start:
  - Latch all cfg_* inputs. Later config changes are ignored until the next start.
  - TDATA ← first_pattern, remaining ← frame_count, frames_issued ← 0, busy ← 1, go to ISSUE.
- ISSUE handshake (TVALID & TREADY):
  - frames_issued += 1, wrapping mod 2^COUNT_WIDTH.
  - TDATA += increment, wrapping mod 2^PATTERN_WIDTH.
  - If the latched count ≠ 0, decrement remaining.
- After the handshake, in priority order:
  1. Last pattern issued (count ≠ 0 and remaining was 1), or a stop is pending or arrives this cycle: go to IDLE, done=1 for one cycle, busy ← 0, TVALID ← 0.
  2. Gap = 0: stay in ISSUE with TVALID held high and the new TDATA (back-to-back issues).
  3. Otherwise: go to GAP, gap counter ← gap−1, TVALID ← 0.
- Stop in ISSUE without a handshake: set stop_pending. TVALID and TDATA stay stable until the handshake; dropping TVALID before the handshake is forbidden.
- GAP:
  - Counter decrements each cycle. When it reads 0, go to ISSUE with TVALID ← 1.
  - Stop in GAP: go to IDLE on the next edge with a done pulse; no further pattern is issued.
- Start while busy: ignored. Stop while idle: ignored. Start and stop in the same idle cycle: start wins and the stop is discarded.
- Continuous mode (count = 0) runs until stop. frames_issued wraps; it does not saturate.
- stop_pending is cleared on entry to IDLE.

## Timing
- Reset values: AXIS_OUT_TVALID=0, AXIS_OUT_TDATA=0, busy=0, done=0, frames_issued=0, state=IDLE, stop_pending=0.
- Reset is asynchronous and overrides everything mid-run. No done pulse is produced for a run aborted by reset.
- Start sampled at edge N gives TVALID=1 and busy=1 from cycle N+1.
- Handshake at edge N with gap G>0 gives TVALID low for cycles N+1..N+G and high again at N+G+1.
- Handshake at edge N with G=0 keeps TVALID high at N+1 with the incremented data.
- done is high in cycle N+1 after the final handshake or the stop edge N. busy falls in the same cycle.
- frames_issued updates in the cycle after each handshake.
- TDATA and TVALID are registered outputs; there is no combinational path from TREADY to any output.

## Structure
- Shared package `simframe_pkg`:
  - State enum (IDLE, ISSUE, GAP).
  - Default PATTERN_WIDTH and COUNT_WIDTH constants, shared with the frame generator.
- Single module; no sub-module is needed. The gap counter and the remaining counter are inline registers.

## Test plan
- Finite run: first=0x10, inc=1, count=3, gap=0, TREADY=1. Expect TDATA 0x10, 0x11, 0x12 on three consecutive cycles, then done pulse, busy=0, frames_issued=3.
- Gap and backpressure: count=2, gap=4, TREADY held low 5 cycles after TVALID rises. Expect TVALID and TDATA stable until the handshake, then exactly 4 low cycles, then the second pattern.
- Wrap: first=0xFFFFFFFF, inc=2, count=2. Expect 0xFFFFFFFF then 0x00000001.
- Stop in ISSUE while TREADY=0, continuous mode. Expect TVALID held until the handshake, then done on the next cycle, frames_issued equal to the accepted count, no further TVALID.
- Stop in GAP with gap=10 after 1 issue. Expect done the next cycle, frames_issued=1, no second issue. Start and stop together in IDLE starts a run; start while busy changes nothing.
- Async reset asserted mid-ISSUE (between edges). Expect TVALID=0, busy=0 and TDATA=0 immediately, no done pulse, and a clean new run after release and start.
